// File: rtl/gpio_pos_pkg.sv
// ============================================================================
//  Module : gpio_pos_pkg
//  Shared state type and default timing for the GPIO position sampler.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package gpio_pos_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_LOCKED = 2'd2,
        S_HOLD   = 2'd3
    } pos_state_t;

    localparam int STABLE_10MS_25M = 250000;
    localparam int LOST_100MS_25M  = 2500000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_pos_sampler_sync2.sv
// ============================================================================
//  Module : sync2
//  Generic 2-flop synchronizer for asynchronous input buses.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync2 #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
        end
    end

    assign o_q = sync_q;

endmodule

`default_nettype wire

// File: rtl/gpio_pos_sampler.sv
// ============================================================================
//  Module : gpio_pos_sampler
//  Synchronises, debounces and bridges dropouts of the sensor detect/position.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gpio_pos_sampler
    import gpio_pos_pkg::*;
#(
    parameter int POS_W      = 3,
    parameter int STABLE_CYC = STABLE_10MS_25M,
    parameter int LOST_CYC   = LOST_100MS_25M
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_detect,
    input  logic [POS_W-1:0] i_pos,
    output logic [POS_W-1:0] o_pos,
    output logic             o_valid,
    output logic             o_pos_chg,
    output logic             o_lost
);

    localparam int MAX_CYC = max_int(STABLE_CYC, LOST_CYC);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] LOST_LAST   = CNT_W'(LOST_CYC - 1);

    logic [POS_W:0]   sync_w;
    logic             det_w;
    logic [POS_W-1:0] pos_w;

    sync2 #(.W(POS_W + 1)) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     ({i_detect, i_pos}),
        .o_q     (sync_w)
    );

    assign det_w = sync_w[POS_W];
    assign pos_w = sync_w[POS_W-1:0];

    pos_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0] cand_q, cand_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             valid_q, valid_d;
    logic             chg_q, chg_d;
    logic             lost_q, lost_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        pos_d   = pos_q;
        valid_d = valid_q;
        chg_d   = 1'b0;
        lost_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (det_w) begin
                    state_d = S_SETTLE;
                    cand_d  = pos_w;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (!det_w) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (pos_w != cand_q) begin
                    cand_d = pos_w;
                    cnt_d  = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_LOCKED;
                    pos_d   = cand_q;
                    valid_d = 1'b1;
                    chg_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOCKED: begin
                // Detect loss wins over any simultaneous position movement.
                if (!det_w) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else if (pos_w == pos_q) begin
                    cand_d = pos_q;
                    cnt_d  = '0;
                end else if (pos_w != cand_q) begin
                    cand_d = pos_w;
                    cnt_d  = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    pos_d = cand_q;
                    chg_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (det_w) begin
                    state_d = S_LOCKED;
                    cnt_d   = '0;
                end else if (cnt_q == LOST_LAST) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    lost_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            pos_q   <= '0;
            valid_q <= 1'b0;
            chg_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            pos_q   <= pos_d;
            valid_q <= valid_d;
            chg_q   <= chg_d;
            lost_q  <= lost_d;
        end
    end

    assign o_pos     = pos_q;
    assign o_valid   = valid_q;
    assign o_pos_chg = chg_q;
    assign o_lost    = lost_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_pos_sampler.sv
// ============================================================================
//  Module : tb_gpio_pos_sampler
//  Directed and randomized checks of gpio_pos_sampler against a reference model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gpio_pos_sampler;

    localparam int POS_W = 3;
    localparam int STAB  = 4;
    localparam int LOST  = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_detect = 1'b0;
    logic [POS_W-1:0] i_pos = '0;
    logic [POS_W-1:0] o_pos;
    logic             o_valid;
    logic             o_pos_chg;
    logic             o_lost;

    int checks = 0;
    int errors = 0;

    gpio_pos_sampler #(.POS_W(POS_W), .STABLE_CYC(STAB), .LOST_CYC(LOST)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_detect  (i_detect),
        .i_pos     (i_pos),
        .o_pos     (o_pos),
        .o_valid   (o_valid),
        .o_pos_chg (o_pos_chg),
        .o_lost    (o_lost)
    );

    always #20 clk = ~clk;

    // Reference model: the raw inputs seen two edges ago drive a tracker that
    // counts how long the current candidate and the current dropout have lasted.
    bit             hist_det[$];
    bit [POS_W-1:0] hist_pos[$];
    int             phase;          // 0 searching, 1 qualifying, 2 locked, 3 dropout
    int             run_len;
    bit [POS_W-1:0] m_cand, m_pos;
    bit             m_valid, m_chg, m_lost;

    task automatic model_reset();
        hist_det = '{1'b0, 1'b0};
        hist_pos = '{3'd0, 3'd0};
        phase = 0; run_len = 0;
        m_cand = '0; m_pos = '0;
        m_valid = 1'b0; m_chg = 1'b0; m_lost = 1'b0;
    endtask

    task automatic model_edge(input bit d_raw, input bit [POS_W-1:0] p_raw);
        bit             d;
        bit [POS_W-1:0] p;
        hist_det.push_back(d_raw);
        hist_pos.push_back(p_raw);
        d = hist_det.pop_front();
        p = hist_pos.pop_front();
        m_chg  = 1'b0;
        m_lost = 1'b0;
        if (phase == 0) begin
            if (d) begin phase = 1; m_cand = p; run_len = 0; end
        end else if (phase == 1) begin
            if (!d) begin phase = 0; run_len = 0; end
            else if (p != m_cand) begin m_cand = p; run_len = 0; end
            else if (run_len + 1 >= STAB) begin
                phase = 2; m_pos = m_cand; m_valid = 1'b1; m_chg = 1'b1; run_len = 0;
            end else run_len++;
        end else if (phase == 2) begin
            if (!d) begin phase = 3; run_len = 0; end
            else if (p == m_pos) begin m_cand = m_pos; run_len = 0; end
            else if (p != m_cand) begin m_cand = p; run_len = 0; end
            else if (run_len + 1 >= STAB) begin m_pos = m_cand; m_chg = 1'b1; run_len = 0; end
            else run_len++;
        end else begin
            if (d) begin phase = 2; run_len = 0; end
            else if (run_len + 1 >= LOST) begin
                phase = 0; m_valid = 1'b0; m_lost = 1'b1; run_len = 0;
            end else run_len++;
        end
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0b want %0b", tag, got, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input logic [POS_W-1:0] got, input logic [POS_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk_pos({tag, ".pos"},   o_pos,     m_pos);
        chk_bit({tag, ".valid"}, o_valid,   m_valid);
        chk_bit({tag, ".chg"},   o_pos_chg, m_chg);
        chk_bit({tag, ".lost"},  o_lost,    m_lost);
    endtask

    task automatic step(input bit d, input bit [POS_W-1:0] p, input string tag);
        i_detect = d;
        i_pos    = p;
        @(posedge clk);
        #1;
        model_edge(d, p);
        check_model(tag);
    endtask

    task automatic check_zero(input string tag);
        chk_pos({tag, ".pos0"},   o_pos,     3'd0);
        chk_bit({tag, ".valid0"}, o_valid,   1'b0);
        chk_bit({tag, ".chg0"},   o_pos_chg, 1'b0);
        chk_bit({tag, ".lost0"},  o_lost,    1'b0);
    endtask

    // Assert reset between edges, confirm outputs clear at once, release after an edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int pulses;

    initial begin
        model_reset();
        #5;
        check_zero("por");
        do_reset("rst1");

        // Initial acquisition: pulse exactly on the 7th edge after inputs settle.
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 3'd5, "acq");
            chk_bit("acq.chg_at7",   o_pos_chg, k == 7);
            chk_bit("acq.valid_ge7", o_valid,   k >= 7);
            chk_bit("acq.nolost",    o_lost,    1'b0);
        end
        chk_pos("acq.pos5", o_pos, 3'd5);

        // Position chatter shorter than the stability window is rejected.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                step(1'b1, (k < 2) ? 3'd3 : 3'd5, "chatter");
                chk_bit("chatter.nochg", o_pos_chg, 1'b0);
            end
        end
        chk_pos("chatter.pos5", o_pos, 3'd5);

        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 3'd3, "move");
            if (o_pos_chg) pulses++;
            chk_bit("move.chg_at7", o_pos_chg, k == 7);
        end
        checks++;
        assert (pulses == 1) else begin
            errors++;
            $error("FAIL move.pulses got %0d want 1", pulses);
        end
        chk_pos("move.pos3", o_pos, 3'd3);

        // Short detect dropout is bridged.
        for (int k = 0; k < 11; k++) begin
            step((k >= 5), 3'd3, "bridge");
            chk_bit("bridge.valid",  o_valid, 1'b1);
            chk_bit("bridge.nolost", o_lost,  1'b0);
        end
        chk_pos("bridge.pos3", o_pos, 3'd3);

        // Detect falls together with a position change: position must not move.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 3'd6, "simul");
            chk_pos("simul.pos3", o_pos, 3'd3);
            chk_bit("simul.valid", o_valid, 1'b1);
        end
        for (int k = 0; k < 6; k++) step(1'b1, 3'd3, "relock");
        chk_pos("relock.pos3", o_pos, 3'd3);

        // Sustained dropout: lost pulse on the 11th edge after the drop.
        for (int k = 1; k <= 14; k++) begin
            step(1'b0, 3'd3, "lost");
            chk_bit("lost.at11",   o_lost,  k == 11);
            chk_bit("lost.valid",  o_valid, k < 11);
        end
        chk_pos("lost.stale3", o_pos, 3'd3);

        // Reset while qualifying, then a full fresh acquisition.
        for (int k = 0; k < 5; k++) step(1'b1, 3'd2, "presettle");
        do_reset("rst_mid");
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 3'd2, "reacq");
            chk_bit("reacq.chg_at7", o_pos_chg, k == 7);
        end
        chk_pos("reacq.pos2", o_pos, 3'd2);

        // Randomized segments held for random durations.
        for (int s = 0; s < 400; s++) begin
            bit             d;
            bit [POS_W-1:0] p;
            int             len;
            d   = ($urandom_range(0, 9) < 8);
            p   = POS_W'($urandom);
            len = (s % 7 == 0) ? $urandom_range(9, 14) : $urandom_range(1, 8);
            for (int k = 0; k < len; k++) step(d, p, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
